// File: rtl/cordic16_seq.sv
// Iterative 16-bit CORDIC engine: one micro-rotation per clock, using an arithmetic
// right shift by the iteration index and a 16-entry arctangent ROM.
module cordic16_seq #(
  parameter int NITER = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  output logic        busy,
  output logic        done,
  output logic [3:0]  shamt,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic [15:0] z_out
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t             state, state_n;
  logic [3:0]         cnt;
  logic               mode_r;
  logic [15:0]        x, y, z;
  logic signed [15:0] xs, ys;
  logic [15:0]        atan_i;
  logic               dpos;

  function automatic logic [15:0] atan_rom(input logic [3:0] i);
    case (i)
      4'd0:    atan_rom = 16'h2000;
      4'd1:    atan_rom = 16'h12E4;
      4'd2:    atan_rom = 16'h09FB;
      4'd3:    atan_rom = 16'h0511;
      4'd4:    atan_rom = 16'h028B;
      4'd5:    atan_rom = 16'h0146;
      4'd6:    atan_rom = 16'h00A3;
      4'd7:    atan_rom = 16'h0051;
      4'd8:    atan_rom = 16'h0029;
      4'd9:    atan_rom = 16'h0014;
      4'd10:   atan_rom = 16'h000A;
      4'd11:   atan_rom = 16'h0005;
      4'd12:   atan_rom = 16'h0003;
      4'd13:   atan_rom = 16'h0001;
      4'd14:   atan_rom = 16'h0001;
      default: atan_rom = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ITER;
      ITER:    if (cnt == 4'(NITER - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Rotation steers z toward 0, vectoring steers y toward 0; sign taken from bit 15.
  assign dpos   = mode_r ? y[15] : ~z[15];
  assign xs     = $signed(x) >>> cnt;
  assign ys     = $signed(y) >>> cnt;
  assign atan_i = atan_rom(cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 4'd0;
      mode_r <= 1'b0;
      x      <= 16'h0000;
      y      <= 16'h0000;
      z      <= 16'h0000;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt    <= 4'd0;
          mode_r <= mode;
          x      <= x_in;
          y      <= y_in;
          z      <= z_in;
        end
        ITER: begin
          x   <= dpos ? x - ys     : x + ys;
          y   <= dpos ? y + xs     : y - xs;
          z   <= dpos ? z - atan_i : z + atan_i;
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign shamt = (state == ITER) ? cnt : 4'd0;
  assign x_out = x;
  assign y_out = y;
  assign z_out = z;

endmodule

// File: doc/cordic16_seq.md
Name: cordic16_seq

Overview:
- Iterative 16-bit CORDIC engine that sequences the arithmetic right log-shifter (1/2/4/8 stages) over NITER iterations.
- Owns the iteration counter, the shift amount that drives the shifter, the arctangent ROM, the x/y/z add/sub registers and the start/done handshake.
- Sits between the rotation/vectoring requester and the shared shifter datapath in the cordic16 design.

Parameters:
- NITER, 16, number of micro-rotations; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); sampled with start.
- x_in  input  16  signed Q2.14 initial x.
- y_in  input  16  signed Q2.14 initial y.
- z_in  input  16  signed angle; 0x8000 = -pi, 0x4000 = +pi/2.
- busy  output  1  high from the accepting edge until return to IDLE.
- done  output  1  one-cycle pulse; results valid.
- shamt  output  4  current iteration index, driven to the shifter sh bits.
- x_out  output  16  result x.
- y_out  output  16  result y.
- z_out  output  16  result z.

Behaviour:
- Reset: state=IDLE; cnt=0; busy=0; done=0; shamt=0; x/y/z registers=0.
- Reset asserted mid-operation aborts the operation the same edge. No done pulse is produced.
- FSM states and transitions:
  - IDLE -> ITER on an edge with start=1. That edge loads x_in/y_in/z_in and mode, sets cnt=0, busy=1.
  - ITER: each edge performs iteration i=cnt, then increments cnt. The edge where cnt=NITER-1 moves to DONE and sets done=1.
  - DONE -> IDLE on the next edge: done=0, busy=0.
- Latency: start high at edge E0 gives done high during the cycle after edge E0+NITER. The result is available NITER+1 cycles after start is sampled.
- start is ignored in ITER and DONE. start held high in IDLE after DONE begins a new operation; back-to-back throughput is one result per NITER+2 cycles.
- shamt equals cnt in ITER and is 0 otherwise.
- Direction per iteration:
  - d=+1 if (mode=0 and z>=0) or (mode=1 and y<0); otherwise d=-1.
  - Sign tests use bit 15 of the current registers.
- Update per iteration, all three registers simultaneously from old values:
  - x' = x - d*(y>>>i)
  - y' = y + d*(x>>>i)
  - z' = z - d*atan[i]
- Arithmetic rules:
  - >>> is arithmetic right shift with sign fill, identical to the log-shifter (shift 15 of a negative value gives 0xFFFF).
  - All sums are 16-bit two's complement and wrap. There is no saturation or overflow flag.
- atan ROM, indices 0..15: 0x2000, 0x12E4, 0x09FB, 0x0511, 0x028B, 0x0146, 0x00A3, 0x0051, 0x0029, 0x0014, 0x000A, 0x0005, 0x0003, 0x0001, 0x0001, 0x0000.
- No gain compensation: the caller pre-scales by K^-1 (0x26DD for 1.0).
- Outputs:
  - x_out/y_out/z_out reflect the registers at all times and are valid when done=1.
  - They hold their values through IDLE until the next accepted start.

Test Plan:
- Reset during ITER: start, then reset at cnt=5 -> next cycle busy=0, done=0, shamt=0, outputs 0. done never pulses; a subsequent start completes normally.
- NITER=1 exact rotation: start, mode=0, x=0x1000, y=0, z=0x0100 -> done in cycle E0+2 with x_out=0x1000, y_out=0x1000, z_out=0xE100. busy high for exactly 2 cycles.
- NITER=1 wrap: mode=0, x=0x7000, y=0x7000, z=0 -> x_out=0x0000, y_out=0xE000 (wrapped, no saturation).
- NITER=16 rotation: x=0x26DD, y=0, z=0x2000 -> x_out and y_out each 0x2D41 +/-8 LSB, |z_out|<=4. done exactly 17 cycles after the start edge; shamt steps 0..15.
- NITER=16 vectoring: mode=1, x=0x2000, y=0x2000, z=0 -> |y_out|<=8, z_out=0x2000 +/-4, x_out=0x4A87 +/-8.
- Handshake: start held high continuously -> ignored during ITER/DONE. A new operation is accepted on the first IDLE edge, so done pulses every 18 cycles. Outputs hold steady in IDLE with start=0.
